// File: rtl/keys_pio_event_servicer.sv
// keys_pio_event_servicer
//   Avalon-MM master for the 4-bit keys PIO. After reset it writes the PIO
//   irq_mask once. On each PIO irq it reads edge_capture, clears exactly the
//   bits it read, and queues one key-event record in a first-word-fall-through
//   FIFO for the game logic.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   o_pio_*               PIO bus: address, chipselect, write_n, writedata
//   i_pio_readdata        PIO read data, valid the cycle after the address
//   i_pio_irq             PIO interrupt
//   o_evt_valid/i_evt_ready, o_evt_keys, o_evt_time   event FIFO head
//   o_overflow            sticky: an event was dropped on a full FIFO
//
// Build option
//   KEYS_SVC_TIMESTAMP_EN  when defined, a free-running TS_WIDTH counter is
//                          stamped into each event; otherwise o_evt_time = 0.
//
// state | meaning
// INIT  | write KEY_MASK to irq_mask (addr 2)
// IDLE  | bus idle, wait for pio_irq
// RD    | read edge_capture (addr 3)
// CAP   | capture read data; zero means spurious irq
// CLR   | write captured bits back to edge_capture to clear them
// PUSH  | queue the event, or drop it and flag overflow
module keys_pio_event_servicer #(
  parameter logic [3:0] KEY_MASK   = 4'hF,
  parameter int         FIFO_DEPTH = 8,
  parameter int         TS_WIDTH   = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  output logic [1:0]          o_pio_address,
  output logic                o_pio_chipselect,
  output logic                o_pio_write_n,
  output logic [31:0]         o_pio_writedata,
  input  logic [31:0]         i_pio_readdata,
  input  logic                i_pio_irq,
  output logic                o_evt_valid,
  input  logic                i_evt_ready,
  output logic [3:0]          o_evt_keys,
  output logic [TS_WIDTH-1:0] o_evt_time,
  output logic                o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD, S_CAP, S_CLR, S_PUSH
  } state_t;

  state_t r_state, w_state_next;

  logic [3:0]  r_cap;
  logic        r_cs, r_wr_n;
  logic [1:0]  r_addr;
  logic [31:0] r_wdata;
  logic        w_cs, w_wr_n;
  logic [1:0]  w_addr;
  logic [31:0] w_wdata;

  logic [3:0]       r_mem_keys [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_pop, w_full, w_push, w_drop;
  logic             w_unused_rdata;

  assign w_unused_rdata = ^i_pio_readdata[31:4];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_INIT;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT: w_state_next = S_IDLE;
      S_IDLE: if (i_pio_irq) w_state_next = S_RD;
      S_RD:   w_state_next = S_CAP;
      S_CAP:  w_state_next = (i_pio_readdata[3:0] != 4'h0) ? S_CLR : S_IDLE;
      S_CLR:  w_state_next = S_PUSH;
      S_PUSH: w_state_next = S_IDLE;
      default: w_state_next = S_INIT;
    endcase
  end

  // Bus signals are registered from the state being entered, so each cycle
  // shows the transaction of the current state with no input->output path.
  // The mask write is issued in the cycle after INIT so that reset leaves the
  // bus idle for one cycle before the write appears.
  always_comb begin
    w_cs    = 1'b0;
    w_wr_n  = 1'b1;
    w_addr  = 2'd0;
    w_wdata = 32'd0;
    if (r_state == S_INIT) begin
      w_cs    = 1'b1;
      w_wr_n  = 1'b0;
      w_addr  = 2'd2;
      w_wdata = {28'd0, KEY_MASK};
    end else begin
      case (w_state_next)
        S_RD: begin
          w_cs   = 1'b1;
          w_addr = 2'd3;
        end
        S_CAP: w_addr = 2'd3;
        S_CLR: begin
          // Entered from CAP, so the read data is exactly what gets captured.
          w_cs    = 1'b1;
          w_wr_n  = 1'b0;
          w_addr  = 2'd3;
          w_wdata = {28'd0, i_pio_readdata[3:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cs    <= 1'b0;
      r_wr_n  <= 1'b1;
      r_addr  <= 2'd0;
      r_wdata <= 32'd0;
      r_cap   <= 4'h0;
    end else begin
      r_cs    <= w_cs;
      r_wr_n  <= w_wr_n;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      if (r_state == S_CAP) r_cap <= i_pio_readdata[3:0];
    end
  end

  assign o_pio_chipselect = r_cs;
  assign o_pio_write_n    = r_wr_n;
  assign o_pio_address    = r_addr;
  assign o_pio_writedata  = r_wdata;

  // A pop in the PUSH cycle frees the slot even when full.
  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = (r_count != '0) && i_evt_ready;
  assign w_push = (r_state == S_PUSH) && (!w_full || w_pop);
  assign w_drop = (r_state == S_PUSH) && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem_keys[r_wr_ptr] <= r_cap;
  end

  assign o_evt_valid = (r_count != '0);
  assign o_evt_keys  = o_evt_valid ? r_mem_keys[r_rd_ptr] : 4'h0;
  assign o_overflow  = r_overflow;

`ifdef KEYS_SVC_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_mem_ts [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_ts <= '0;
    else         r_ts <= r_ts + TS_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem_ts[r_wr_ptr] <= r_ts;
  end

  assign o_evt_time = o_evt_valid ? r_mem_ts[r_rd_ptr] : '0;
`else
  assign o_evt_time = '0;
`endif

endmodule
